// File: rtl/palette_lut_if.sv
// Pixel lookup, palette write and fade control bundle for palette_lut.
// master = compositor side, slave = lookup table.
interface palette_lut_if #(
    parameter int IDX_W = 4
);
    logic             pix_valid_in;
    logic [IDX_W-1:0] pix_idx;
    logic             pix_valid_out;
    logic [7:0]       VGA_R;
    logic [7:0]       VGA_G;
    logic [7:0]       VGA_B;
    logic             transparent;
    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_idx;
    logic [23:0]      wr_color;
    logic             frame_start;
    logic             fade_go;
    logic             fade_dir;
    logic             fade_busy;
    logic [7:0]       fade_level;

    modport master (
        output pix_valid_in, pix_idx,
        output wr_valid, wr_idx, wr_color,
        output frame_start, fade_go, fade_dir,
        input  pix_valid_out, VGA_R, VGA_G, VGA_B,
        input  transparent, wr_ready,
        input  fade_busy, fade_level
    );

    modport slave (
        input  pix_valid_in, pix_idx,
        input  wr_valid, wr_idx, wr_color,
        input  frame_start, fade_go, fade_dir,
        output pix_valid_out, VGA_R, VGA_G, VGA_B,
        output transparent, wr_ready,
        output fade_busy, fade_level
    );
endinterface

// File: rtl/palette_lut.sv
// Colour lookup table: 2-stage index->RGB pipeline, writable entries.
// Optional frame-synchronous fade engine when PALETTE_FADE_EN is defined.
module palette_lut #(
    parameter int IDX_W       = 4,
    parameter int TRANSP_IDX  = 0,
    parameter int LOCK_TRANSP = 1,
    parameter int FADE_STEP   = 17
) (
    input logic          Clk,
    input logic          Reset_n,
    palette_lut_if.slave bus
);
    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] TIDX = IDX_W'(TRANSP_IDX);

    function automatic logic [23:0] dflt(input int i);
        case (i)
            1:       return 24'h05121B;
            2:       return 24'h2D4745;
            3:       return 24'h46615B;
            4:       return 24'h082026;
            5:       return 24'h223A42;
            6:       return 24'h000000;
            7:       return 24'hBDBFA0;
            8:       return 24'hFE9802;
            9:       return 24'h9A9A9A;
            10:      return 24'h16252F;
            11:      return 24'hD624C1;
            12:      return 24'hFFFFFF;
            default: return 24'hFF0000;
        endcase
    endfunction

    logic [23:0] tbl [DEPTH];
    logic        wr_rdy;
    logic        wr_ok;

    assign bus.wr_ready = wr_rdy;
    assign wr_ok = bus.wr_valid && wr_rdy &&
                   !(LOCK_TRANSP != 0 && bus.wr_idx == TIDX);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                tbl[i] <= dflt(i);
            wr_rdy <= 1'b0;
        end else begin
            wr_rdy <= 1'b1;
            if (wr_ok)
                tbl[bus.wr_idx] <= bus.wr_color;
        end
    end

    // Stage 1 reads the pre-write table, so a same-cycle write is not seen.
    logic        s1_v;
    logic [23:0] s1_c;
    logic        s1_t;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1_v <= 1'b0;
            s1_c <= 24'h0;
            s1_t <= 1'b0;
        end else begin
            s1_v <= bus.pix_valid_in;
            if (bus.pix_valid_in) begin
                s1_c <= tbl[bus.pix_idx];
                s1_t <= bus.pix_idx == TIDX;
            end
        end
    end

    logic [23:0] s2_c;

`ifdef PALETTE_FADE_EN
    typedef enum logic {IDLE, RUN} fstate_t;

    fstate_t    st;
    logic [7:0] lvl;
    logic       busy;
    logic       dir_r;
    logic [8:0] up;
    logic [7:0] dn;
    logic [7:0] nxt;
    logic [7:0] end_lvl;

    assign up      = {1'b0, lvl} + 9'(FADE_STEP);
    assign dn      = lvl > 8'(FADE_STEP) ? lvl - 8'(FADE_STEP) : 8'h00;
    assign nxt     = dir_r ? (up[8] ? 8'hFF : up[7:0]) : dn;
    assign end_lvl = dir_r ? 8'hFF : 8'h00;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            st    <= IDLE;
            lvl   <= 8'hFF;
            busy  <= 1'b0;
            dir_r <= 1'b0;
        end else begin
            unique case (st)
                IDLE: if (bus.fade_go) begin
                    lvl   <= bus.fade_dir ? 8'h00 : 8'hFF;
                    dir_r <= bus.fade_dir;
                    busy  <= 1'b1;
                    st    <= RUN;
                end
                RUN: if (bus.frame_start) begin
                    lvl <= nxt;
                    if (nxt == end_lvl) begin
                        busy <= 1'b0;
                        st   <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    // (c * (level + 1)) >> 8: level 255 is identity, level 0 is black.
    function automatic logic [7:0] scale(
        input logic [7:0] c,
        input logic [7:0] l
    );
        logic [8:0] m;
        m = {1'b0, l} + 9'd1;
        return 8'(({8'b0, c} * {7'b0, m}) >> 8);
    endfunction

    assign s2_c = {scale(s1_c[23:16], lvl),
                   scale(s1_c[15:8], lvl),
                   scale(s1_c[7:0], lvl)};
    assign bus.fade_busy  = busy;
    assign bus.fade_level = lvl;
`else
    logic unused_fade;
    assign unused_fade = bus.fade_go ^ bus.fade_dir ^ bus.frame_start;
    assign s2_c           = s1_c;
    assign bus.fade_busy  = 1'b0;
    assign bus.fade_level = 8'hFF;
`endif

    logic        vo;
    logic [23:0] oc;
    logic        ot;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            vo <= 1'b0;
            oc <= 24'h0;
            ot <= 1'b0;
        end else begin
            vo <= s1_v;
            if (s1_v) begin
                oc <= s2_c;
                ot <= s1_t;
            end
        end
    end

    assign bus.pix_valid_out = vo;
    assign bus.VGA_R         = oc[23:16];
    assign bus.VGA_G         = oc[15:8];
    assign bus.VGA_B         = oc[7:0];
    assign bus.transparent   = ot;
endmodule

// File: tb/tb_palette_lut.sv
// Directed vector bench for palette_lut (lookup, write, lock, fade, reset).
module tb_palette_lut;
    logic Clk = 1'b0;
    logic Reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 Clk = ~Clk;

    palette_lut_if #(.IDX_W(4)) bus ();

    palette_lut #(
        .IDX_W(4),
        .TRANSP_IDX(0),
        .LOCK_TRANSP(1),
        .FADE_STEP(64)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]  idx;
        logic [23:0] rgb;
        logic        tr;
    } vec_t;

    vec_t vt [16];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] rgb();
        return {bus.VGA_R, bus.VGA_G, bus.VGA_B};
    endfunction

    // One isolated lookup; result visible after two edges.
    task automatic look(input logic [3:0] i, output logic [23:0] c,
                        output logic t, output logic v);
        bus.pix_valid_in = 1'b1;
        bus.pix_idx      = i;
        tick();
        bus.pix_valid_in = 1'b0;
        tick();
        c = rgb();
        t = bus.transparent;
        v = bus.pix_valid_out;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
    endtask

    logic [23:0] c;
    logic        t;
    logic        v;
    logic [7:0]  lv [4];

    initial begin
        vt[0]  = '{4'd0,  24'hFF0000, 1'b1};
        vt[1]  = '{4'd1,  24'h05121B, 1'b0};
        vt[2]  = '{4'd2,  24'h2D4745, 1'b0};
        vt[3]  = '{4'd3,  24'h46615B, 1'b0};
        vt[4]  = '{4'd4,  24'h082026, 1'b0};
        vt[5]  = '{4'd5,  24'h223A42, 1'b0};
        vt[6]  = '{4'd6,  24'h000000, 1'b0};
        vt[7]  = '{4'd7,  24'hBDBFA0, 1'b0};
        vt[8]  = '{4'd8,  24'hFE9802, 1'b0};
        vt[9]  = '{4'd9,  24'h9A9A9A, 1'b0};
        vt[10] = '{4'd10, 24'h16252F, 1'b0};
        vt[11] = '{4'd11, 24'hD624C1, 1'b0};
        vt[12] = '{4'd12, 24'hFFFFFF, 1'b0};
        vt[13] = '{4'd13, 24'hFF0000, 1'b0};
        vt[14] = '{4'd14, 24'hFF0000, 1'b0};
        vt[15] = '{4'd15, 24'hFF0000, 1'b0};

        bus.pix_valid_in = 1'b0;
        bus.pix_idx      = '0;
        bus.wr_valid     = 1'b0;
        bus.wr_idx       = '0;
        bus.wr_color     = '0;
        bus.frame_start  = 1'b0;
        bus.fade_go      = 1'b0;
        bus.fade_dir     = 1'b0;
        Reset_n          = 1'b0;
        tick();
        tick();

        chk("rst_valid", 32'(bus.pix_valid_out), 32'd0);
        chk("rst_rgb", 32'(rgb()), 32'd0);
        chk("rst_transp", 32'(bus.transparent), 32'd0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("rst_busy", 32'(bus.fade_busy), 32'd0);
        chk("rst_level", 32'(bus.fade_level), 32'd255);
        Reset_n = 1'b1;
        tick();
        chk("wr_ready_up", 32'(bus.wr_ready), 32'd1);

        // Back-to-back sweep: output at iteration k belongs to vector k-1.
        for (int k = 0; k < 18; k++) begin
            bus.pix_valid_in = k < 16;
            bus.pix_idx      = (k < 16) ? vt[k].idx : 4'd0;
            tick();
            if (k >= 1 && k <= 16) begin
                chk($sformatf("sweep_v%0d", k - 1),
                    32'(bus.pix_valid_out), 32'd1);
                chk($sformatf("sweep_rgb%0d", k - 1),
                    32'(rgb()), 32'(vt[k - 1].rgb));
                chk($sformatf("sweep_tr%0d", k - 1),
                    32'(bus.transparent), 32'(vt[k - 1].tr));
            end else begin
                chk($sformatf("sweep_bub%0d", k),
                    32'(bus.pix_valid_out), 32'd0);
            end
        end
        bus.pix_valid_in = 1'b0;
        tick();
        chk("hold_rgb", 32'(rgb()), 32'hFF0000);

        // Write 7 with a same-cycle lookup, then lookup again.
        bus.wr_valid     = 1'b1;
        bus.wr_idx       = 4'd7;
        bus.wr_color     = 24'h123456;
        bus.pix_valid_in = 1'b1;
        bus.pix_idx      = 4'd7;
        tick();
        bus.wr_valid     = 1'b0;
        tick();
        chk("wr_same_old", 32'(rgb()), 32'hBDBFA0);
        bus.pix_valid_in = 1'b0;
        tick();
        chk("wr_next_new", 32'(rgb()), 32'h123456);
        tick();
        chk("bubble_v", 32'(bus.pix_valid_out), 32'd0);
        chk("bubble_hold", 32'(rgb()), 32'h123456);

        // Locked transparent entry.
        chk("lock_ready", 32'(bus.wr_ready), 32'd1);
        bus.wr_valid = 1'b1;
        bus.wr_idx   = 4'd0;
        bus.wr_color = 24'h00FF00;
        tick();
        bus.wr_valid = 1'b0;
        look(4'd0, c, t, v);
        chk("lock_rgb", 32'(c), 32'hFF0000);
        chk("lock_tr", 32'(t), 32'd1);

        bus.wr_valid = 1'b1;
        bus.wr_idx   = 4'd15;
        bus.wr_color = 24'hABCDEF;
        tick();
        bus.wr_valid = 1'b0;
        look(4'd15, c, t, v);
        chk("wr15_rgb", 32'(c), 32'hABCDEF);
        chk("wr15_tr", 32'(t), 32'd0);

`ifdef PALETTE_FADE_EN
        lv[0] = 8'd191;
        lv[1] = 8'd127;
        lv[2] = 8'd63;
        lv[3] = 8'd0;
        bus.fade_go  = 1'b1;
        bus.fade_dir = 1'b0;
        tick();
        bus.fade_go = 1'b0;
        chk("fade_start_busy", 32'(bus.fade_busy), 32'd1);
        chk("fade_start_lvl", 32'(bus.fade_level), 32'd255);
        for (int k = 0; k < 4; k++) begin
            bus.frame_start = 1'b1;
            tick();
            bus.frame_start = 1'b0;
            chk($sformatf("fade_lvl%0d", k),
                32'(bus.fade_level), 32'(lv[k]));
            chk($sformatf("fade_busy%0d", k),
                32'(bus.fade_busy), (k == 3) ? 32'd0 : 32'd1);
            look(4'd12, c, t, v);
            chk($sformatf("fade_rgb%0d", k), 32'(c),
                32'({lv[k], lv[k], lv[k]}));
        end
        bus.fade_go  = 1'b1;
        bus.fade_dir = 1'b0;
        tick();
        bus.fade_go     = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("mid_fade_busy", 32'(bus.fade_busy), 32'd1);
`else
        bus.fade_go = 1'b1;
        tick();
        bus.fade_go = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.frame_start = 1'b1;
            tick();
            bus.frame_start = 1'b0;
            chk($sformatf("nofade_lvl%0d", k),
                32'(bus.fade_level), 32'd255);
            chk($sformatf("nofade_busy%0d", k),
                32'(bus.fade_busy), 32'd0);
        end
        look(4'd12, c, t, v);
        chk("nofade_rgb", 32'(c), 32'hFFFFFF);
`endif

        do_reset();
        chk("rst2_busy", 32'(bus.fade_busy), 32'd0);
        chk("rst2_level", 32'(bus.fade_level), 32'd255);
        chk("rst2_valid", 32'(bus.pix_valid_out), 32'd0);
        tick();
        look(4'd7, c, t, v);
        chk("rst2_rgb7", 32'(c), 32'hBDBFA0);
        chk("rst2_v7", 32'(v), 32'd1);
        look(4'd15, c, t, v);
        chk("rst2_rgb15", 32'(c), 32'hFF0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
